multi_channel_power_path: RTL and testbench



---
 rtl/multi_channel_power_path_if.sv | 27 ++
 rtl/multi_channel_power_path.sv | 157 +++++++++++++++
 tb/tb_multi_channel_power_path.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_channel_power_path_if.sv
// Sample-in / power-out bundle for multi_channel_power_path.
// master drives samples and ready; slave is the datapath.
interface multi_channel_power_path_if #(
    parameter int ADC_DW = 12,
    parameter int CW     = 2,
    parameter int PW     = 39
);
    logic              en_i;
    logic [ADC_DW-1:0] sample_i;
    logic [CW-1:0]     ch_i;
    logic              sample_valid_i;
    logic [PW-1:0]     power_o;
    logic [CW-1:0]     ch_o;
    logic              valid_o;
    logic              ready_i;
    logic              overflow_o;

    modport master (
        output en_i, sample_i, ch_i, sample_valid_i, ready_i,
        input  power_o, ch_o, valid_o, overflow_o
    );

    modport slave (
        input  en_i, sample_i, ch_i, sample_valid_i, ready_i,
        output power_o, ch_o, valid_o, overflow_o
    );
endinterface

// File: rtl/multi_channel_power_path.sv
// Interleaved multi-channel receive path: DC removal, fs/4 mix, integrate-and-dump, I^2+Q^2.
// Define MCPP_DC_BLOCK_EN to build the per-channel DC estimator; otherwise y = x.
module multi_channel_power_path #(
    parameter int NUM_CH   = 4,
    parameter int ADC_DW   = 12,
    parameter int DEC_LOG2 = 6,
    parameter int DC_SHIFT = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    multi_channel_power_path_if.slave bus
);
    localparam int ACC_W = ADC_DW + 1 + DEC_LOG2;
    localparam int PW    = 2 * ACC_W + 1;
    localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    if (NUM_CH < 1 || DEC_LOG2 < 2 || DEC_LOG2 > 10 || DC_SHIFT < 1) begin : g_bad_params
        $error("multi_channel_power_path: parameter out of range");
    end

    logic                     accept;
    logic signed [ADC_DW-1:0] x_s, y_s;

    assign accept = bus.sample_valid_i & bus.en_i & (32'(bus.ch_i) < NUM_CH);
    assign x_s    = {~bus.sample_i[ADC_DW-1], bus.sample_i[ADC_DW-2:0]};

`ifdef MCPP_DC_BLOCK_EN
    localparam int DC_W = ADC_DW + DC_SHIFT;
    localparam logic signed [DC_W-1:0] Y_MAX = DC_W'((2 ** (ADC_DW - 1)) - 1);
    localparam logic signed [DC_W-1:0] Y_MIN = -Y_MAX - DC_W'(1);

    function automatic logic signed [ADC_DW-1:0] sat_adc(input logic signed [DC_W-1:0] v);
        if (v > Y_MAX) return Y_MAX[ADC_DW-1:0];
        if (v < Y_MIN) return Y_MIN[ADC_DW-1:0];
        return v[ADC_DW-1:0];
    endfunction

    logic signed [DC_W-1:0] dc [NUM_CH];
    logic signed [DC_W-1:0] dc_cur, dc_err;

    always_comb begin
        dc_cur = dc[bus.ch_i];
        dc_err = DC_W'(x_s) - (dc_cur >>> DC_SHIFT);
        y_s    = sat_adc(dc_err);
    end

    // dc tracks x scaled by 2^DC_SHIFT; its shifted value is the running mean
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) dc[i] <= '0;
        end else if (accept) begin
            dc[bus.ch_i] <= dc_cur + dc_err;
        end
    end
`else
    assign y_s = x_s;
`endif

    logic signed [ADC_DW-1:0]  y_p0;
    logic [CW-1:0]             ch_p0, ch_p1, ch_p2, ch_p3;
    logic                      vld_p0, vld_p1, vld_p2, vld_p3;
    logic signed [ACC_W-1:0]   i_p1, q_p1;
    logic signed [2*ACC_W-1:0] sq_i_p2, sq_q_p2;
    logic [PW-1:0]             pw_p3;

    logic [1:0]                phase [NUM_CH];
    logic [DEC_LOG2-1:0]       cnt   [NUM_CH];
    logic signed [ACC_W-1:0]   acc_i [NUM_CH];
    logic signed [ACC_W-1:0]   acc_q [NUM_CH];

    logic [1:0]                ph_cur;
    logic signed [ADC_DW:0]    y_ext, mix_i, mix_q;
    logic signed [ACC_W-1:0]   sum_i, sum_q;
    logic                      term;

    logic                      valid_r, ovf_r;
    logic [PW-1:0]             power_r;
    logic [CW-1:0]             ch_r;

    // S2: fs/4 mix is a sign/swap selection; no multiplier needed
    always_comb begin
        ph_cur = phase[ch_p0];
        y_ext  = {y_p0[ADC_DW-1], y_p0};
        mix_i  = '0;
        mix_q  = '0;
        case (ph_cur)
            2'd0:    mix_i = y_ext;
            2'd1:    mix_q = -y_ext;
            2'd2:    mix_i = -y_ext;
            default: mix_q = y_ext;
        endcase
        sum_i = acc_i[ch_p0] + ACC_W'(mix_i);
        sum_q = acc_q[ch_p0] + ACC_W'(mix_q);
        term  = (cnt[ch_p0] == {DEC_LOG2{1'b1}});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            vld_p3  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                phase[i] <= '0;
                cnt[i]   <= '0;
                acc_i[i] <= '0;
                acc_q[i] <= '0;
            end
            valid_r <= 1'b0;
            power_r <= '0;
            ch_r    <= '0;
            ovf_r   <= 1'b0;
        end else begin
            vld_p0 <= accept;
            vld_p1 <= vld_p0 & term;
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
            if (vld_p0) begin
                phase[ch_p0] <= ph_cur + 2'd1;
                cnt[ch_p0]   <= cnt[ch_p0] + 1'b1;
                acc_i[ch_p0] <= term ? '0 : sum_i;
                acc_q[ch_p0] <= term ? '0 : sum_q;
            end
            // output holds while stalled; a result arriving then is lost
            if (vld_p3 && (!valid_r || bus.ready_i)) begin
                valid_r <= 1'b1;
                power_r <= pw_p3;
                ch_r    <= ch_p3;
            end else if (valid_r && bus.ready_i) begin
                valid_r <= 1'b0;
            end
            if (vld_p3 && valid_r && !bus.ready_i) ovf_r <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // S1: converted sample
        y_p0    <= y_s;
        ch_p0   <= bus.ch_i;
        // S2: dumped integrator pair
        i_p1    <= sum_i;
        q_p1    <= sum_q;
        ch_p1   <= ch_p0;
        // S3: squares
        sq_i_p2 <= i_p1 * i_p1;
        sq_q_p2 <= q_p1 * q_p1;
        ch_p2   <= ch_p1;
        // S4: exact sum
        pw_p3   <= PW'(sq_i_p2) + PW'(sq_q_p2);
        ch_p3   <= ch_p2;
    end

    assign bus.power_o    = power_r;
    assign bus.ch_o       = ch_r;
    assign bus.valid_o    = valid_r;
    assign bus.overflow_o = ovf_r;
endmodule

// File: tb/tb_multi_channel_power_path.sv
// Directed bench for multi_channel_power_path with a per-channel behavioural model.
// NUM_CH=5 so that an out-of-range tag (5..7) is representable on ch_i.
module tb_multi_channel_power_path;
    localparam int NUM_CH   = 5;
    localparam int ADC_DW   = 12;
    localparam int DEC_LOG2 = 6;
    localparam int DC_SHIFT = 8;
    localparam int ACC_W    = ADC_DW + 1 + DEC_LOG2;
    localparam int PW       = 2 * ACC_W + 1;
    localparam int CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DEC      = 1 << DEC_LOG2;
    localparam longint TONE_PW = 64'd1024000000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multi_channel_power_path_if #(.ADC_DW(ADC_DW), .CW(CW), .PW(PW)) bus ();

    multi_channel_power_path #(
        .NUM_CH(NUM_CH), .ADC_DW(ADC_DW), .DEC_LOG2(DEC_LOG2), .DC_SHIFT(DC_SHIFT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // model: per-channel arithmetic straight from the rules, results timed by accept cycle
    typedef struct { longint due; longint pw; int ch; } res_t;
    typedef struct { longint pw; int ch; } obs_t;
    longint m_acc_i [NUM_CH];
    longint m_acc_q [NUM_CH];
    longint m_dc    [NUM_CH];
    int     m_cnt   [NUM_CH];
    int     m_ph    [NUM_CH];
    res_t   pend[$];
    obs_t   obs[$];
    longint cyc = 0;
    bit     started = 1'b0;
    bit     m_valid, m_ovf, arr;
    longint m_pw;
    int     m_ch;
    res_t   r;

    function automatic void model_sample(input int code, input int c);
        longint x, y, mi, mq, est, d;
        x = longint'(code) - 2048;
`ifdef MCPP_DC_BLOCK_EN
        est = m_dc[c] >>> DC_SHIFT;
        d = x - est;
        y = (d > 2047) ? 2047 : ((d < -2048) ? -2048 : d);
        m_dc[c] += d;
`else
        est = 0;
        d = 0;
        y = x;
`endif
        mi = 0;
        mq = 0;
        case (m_ph[c])
            0: mi = y;
            1: mq = -y;
            2: mi = -y;
            default: mq = y;
        endcase
        m_ph[c] = (m_ph[c] + 1) % 4;
        m_acc_i[c] += mi;
        m_acc_q[c] += mq;
        m_cnt[c]++;
        if (m_cnt[c] == DEC) begin
            pend.push_back('{cyc + 4, m_acc_i[c] * m_acc_i[c] + m_acc_q[c] * m_acc_q[c], c});
            m_acc_i[c] = 0;
            m_acc_q[c] = 0;
            m_cnt[c] = 0;
        end
    endfunction

    always @(posedge clk) begin
        cyc++;
        started = 1'b1;
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_acc_i[i] = 0; m_acc_q[i] = 0; m_dc[i] = 0; m_cnt[i] = 0; m_ph[i] = 0;
            end
            pend.delete();
            m_valid = 1'b0; m_ovf = 1'b0; m_pw = 0; m_ch = 0;
        end else begin
            arr = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                arr = 1'b1;
                r = pend.pop_front();
            end
            if (arr) begin
                if (!m_valid || bus.ready_i) begin
                    m_valid = 1'b1; m_pw = r.pw; m_ch = r.ch;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (m_valid && bus.ready_i) begin
                m_valid = 1'b0;
            end
            if (bus.sample_valid_i && bus.en_i && int'(bus.ch_i) < NUM_CH)
                model_sample(int'(bus.sample_i), int'(bus.ch_i));
        end
    end

    always @(negedge clk) begin
        #1;
        if (started) begin
            chk("valid_o", bus.valid_o, m_valid);
            chk("overflow_o", bus.overflow_o, m_ovf);
            if (m_valid) begin
                chk("power_o", bus.power_o, m_pw);
                chk("ch_o", bus.ch_o, m_ch);
            end
            if (bus.valid_o && bus.ready_i && rst_n)
                obs.push_back('{longint'(bus.power_o), int'(bus.ch_o)});
        end
    end

    function automatic int tone(input int k);
        case (k % 4)
            0: return 3048;
            2: return 1048;
            default: return 2048;
        endcase
    endfunction

    task automatic send(input int code, input int c, input bit en = 1'b1);
        bus.sample_i       = ADC_DW'(code);
        bus.ch_i           = CW'(c);
        bus.en_i           = en;
        bus.sample_valid_i = 1'b1;
        @(negedge clk);
        bus.sample_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    bit     ok;
    longint peak;

    initial begin
        bus.en_i = 1'b0; bus.sample_i = '0; bus.ch_i = '0;
        bus.sample_valid_i = 1'b0; bus.ready_i = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        chk("reset_valid", bus.valid_o, 0);
        chk("reset_power", bus.power_o, 0);
        chk("reset_ch", bus.ch_o, 0);
        chk("reset_ovf", bus.overflow_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // constant +100 on ch0: latency pinned to 4 edges after the 64th accept
        for (int i = 0; i < DEC; i++) send(2148, 0);
        repeat (3) @(negedge clk);
        #2;
        chk("lat_not_early", bus.valid_o, 0);
        @(negedge clk);
        #2;
        chk("lat_valid", bus.valid_o, 1);
        chk("const_ch", bus.ch_o, 0);
`ifndef MCPP_DC_BLOCK_EN
        chk("const_power", bus.power_o, 0);
`endif
        @(negedge clk);

        // fs/4 tone on ch1
        obs.delete();
        for (int i = 0; i < DEC; i++) send(tone(i), 1);
        idle(8);
        chk("tone_count", obs.size(), 1);
        if (obs.size() == 1) begin
            chk("tone_ch", obs[0].ch, 1);
`ifndef MCPP_DC_BLOCK_EN
            chk("tone_power", obs[0].pw, TONE_PW);
`endif
        end

        // constant +500 on ch2 for 4096 samples
        do_reset();
        obs.delete();
        for (int i = 0; i < 4096; i++) send(2548, 2);
        idle(8);
        chk("dc_count", obs.size(), 64);
        if (obs.size() == 64) begin
`ifdef MCPP_DC_BLOCK_EN
            chk("dc_last_small", obs[63].pw < 1000, 1);
            ok = 1'b1;
            peak = obs[1].pw;
            for (int i = 2; i < 64; i++) begin
                if (obs[i].pw > peak) ok = 1'b0;
                if (obs[i].pw > peak) peak = obs[i].pw;
            end
            chk("dc_envelope", ok, 1);
`else
            chk("dc_last_zero", obs[63].pw, 0);
`endif
        end

        // round-robin ch0..3 with ignored out-of-range and disabled samples mixed in
        do_reset();
        obs.delete();
        for (int rr = 0; rr < DEC; rr++) begin
            for (int c = 0; c < 4; c++) begin
                if (c == 0) send(tone(rr), 0);
                else send(int'($urandom_range(4095, 0)), c);
                if (c == 1) send(4000, 5);
                if (c == 2) send(100, 0, 1'b0);
                if (c == 3) send(3500, 7);
            end
        end
        idle(8);
        chk("rr_count", obs.size(), 4);
        if (obs.size() == 4) begin
            for (int c = 0; c < 4; c++) chk("rr_order", obs[c].ch, c);
`ifndef MCPP_DC_BLOCK_EN
            chk("rr_ch0_power", obs[0].pw, TONE_PW);
`endif
        end

        // backpressure: ch0 then ch1 finish while ready is low
        do_reset();
        obs.delete();
        bus.ready_i = 1'b0;
        for (int i = 0; i < DEC; i++) begin
            send(tone(i), 0);
            send(2148, 1);
        end
        idle(6);
        #2;
        chk("bp_held_valid", bus.valid_o, 1);
        chk("bp_held_ch", bus.ch_o, 0);
        chk("bp_ovf_set", bus.overflow_o, 1);
`ifndef MCPP_DC_BLOCK_EN
        chk("bp_held_power", bus.power_o, TONE_PW);
`endif
        @(negedge clk);
        bus.ready_i = 1'b1;
        @(negedge clk);
        #2;
        chk("bp_drained", bus.valid_o, 0);
        chk("bp_ovf_sticky", bus.overflow_o, 1);
        chk("bp_xfer_count", obs.size(), 1);
        if (obs.size() == 1) chk("bp_xfer_ch", obs[0].ch, 0);
        @(negedge clk);

        // reset mid-integration, with a ch1 result still in the pipe
        obs.delete();
        for (int i = 0; i < 30; i++) send(3000, 0);
        for (int i = 0; i < DEC; i++) send(tone(i), 1);
        rst_n = 1'b0;
        @(negedge clk);
        #2;
        chk("rst_mid_valid", bus.valid_o, 0);
        chk("rst_mid_power", bus.power_o, 0);
        chk("rst_mid_ch", bus.ch_o, 0);
        chk("rst_mid_ovf", bus.overflow_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DEC; i++) send(tone(i), 0);
        idle(10);
        chk("rst_mid_count", obs.size(), 1);
        if (obs.size() == 1) begin
            chk("rst_mid_res_ch", obs[0].ch, 0);
`ifndef MCPP_DC_BLOCK_EN
            chk("rst_mid_res_power", obs[0].pw, TONE_PW);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
